// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   One conversion step per clock. The result and its leading-zero flags are
//   registered on the done edge and held until the next conversion finishes,
//   so downstream 7-segment decoders never see intermediate digits.
//
// Parameters
//   IN_W    width of the unsigned binary input
//   DIGITS  number of BCD digits produced; 10**DIGITS must exceed 2**IN_W-1
//
// Ports
//   clk    in   1          system clock, rising edge
//   rst    in   1          synchronous reset, active-high
//   start  in   1          conversion request, accepted only when idle
//   bin    in   IN_W       value to convert, captured on the accepting edge
//   busy   out  1          conversion in progress
//   done   out  1          one-cycle pulse, bcd/blank updated on the same edge
//   bcd    out  4*DIGITS   packed BCD, digit k in bcd[4k+3:4k], digit 0 = ones
//   blank  out  DIGITS     1 = leading-zero digit, blank[0] always 0
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(IN_W + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(IN_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAX_BIN = (longint'(1) << IN_W) - 1;

    generate
        if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_too_few
            $error("bin_to_bcd_seq: DIGITS too small to represent 2**IN_W-1");
        end
    endgenerate

    // Leading-zero flags: digit k (k>=1) is blank when it and every higher
    // digit are zero. The ones digit always shows.
    function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] b;
        logic              z;
        b = '0;
        z = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            z    = z & (d[4*k +: 4] == 4'd0);
            b[k] = z;
        end
        return b;
    endfunction

    logic [0:0]             r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [DIGITS-1:0]      r_blank;
    logic [IN_W-1:0]        r_shift;
    logic [4*DIGITS-1:0]    r_scratch;
    logic [CNT_W-1:0]       r_cnt;

    logic [4*DIGITS-1:0]      w_adj;
    logic [4*DIGITS+IN_W-1:0] w_cat;
    logic [4*DIGITS-1:0]      w_scratch_nxt;
    logic [IN_W-1:0]          w_shift_nxt;

    // Add 3 to any digit >= 5 so that the following doubling carries
    // correctly into the next decimal digit; digits therefore stay <= 9.
    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
        end
    end

    assign w_cat         = {w_adj, r_shift} << 1;
    assign w_scratch_nxt = w_cat[4*DIGITS+IN_W-1 -: 4*DIGITS];
    assign w_shift_nxt   = w_cat[IN_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_blank   <= BLANK_RST;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_scratch <= w_scratch_nxt;
                    r_shift   <= w_shift_nxt;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    // Final step publishes the freshly shifted scratch directly.
                    if (r_cnt == LAST_STEP) begin
                        r_bcd   <= w_scratch_nxt;
                        r_blank <= blank_of(w_scratch_nxt);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign bcd   = r_bcd;
    assign blank = r_blank;

endmodule
